// File: rtl/register_read_stage.sv
// Register-read stage: owns the integer register file, resolves rs_a/rs_b with EX/MEM/WB forwarding, computes the JALR target.
// Latency: 1 cycle from accepting edge to out_valid; throughput 1 bundle/cycle with out_ready high and no load-use hazard.
// Backpressure: in_ready drops on a load-use hazard or when the output register is full and out_ready is low; outputs hold while stalled.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_valid / in_ready       decode-side handshake; rs_a, rs_b, pc_for_a, imm_for_b, pc, imm, exec_op,
//                             cond_branch, taken, jalr form the incoming bundle
//   wb_en, wb_rd, wb_data     register-file write port (also bypassed to same-cycle reads)
//   ex_fwd_*, mem_fwd_*       forwarding sources from execute and memory stages
//   flush                     drops the held and the incoming bundle
//   out_valid / out_ready     execute-side handshake; data_a, data_b, store_data, exec_op_out, cond_branch_out,
//                             taken_out, jalr_out, imm_out, pc_out, jalr_target form the outgoing bundle
module register_read_stage #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int OP_WIDTH  = 5,
    localparam int AW       = $clog2(REG_COUNT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [AW-1:0]       rs_a,
    input  logic [AW-1:0]       rs_b,
    input  logic                pc_for_a,
    input  logic                imm_for_b,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     imm,
    input  logic [OP_WIDTH-1:0] exec_op,
    input  logic                cond_branch,
    input  logic                taken,
    input  logic                jalr,
    input  logic                wb_en,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                ex_fwd_en,
    input  logic [AW-1:0]       ex_fwd_rd,
    input  logic [XLEN-1:0]     ex_fwd_data,
    input  logic                ex_fwd_is_load,
    input  logic                mem_fwd_en,
    input  logic [AW-1:0]       mem_fwd_rd,
    input  logic [XLEN-1:0]     mem_fwd_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     data_a,
    output logic [XLEN-1:0]     data_b,
    output logic [XLEN-1:0]     store_data,
    output logic [OP_WIDTH-1:0] exec_op_out,
    output logic                cond_branch_out,
    output logic                taken_out,
    output logic                jalr_out,
    output logic [XLEN-1:0]     imm_out,
    output logic [XLEN-1:0]     pc_out,
    output logic [XLEN-1:0]     jalr_target
);

    // Register file
    logic [XLEN-1:0] rf_q [REG_COUNT];
    logic [XLEN-1:0] rf_d [REG_COUNT];

    // Output bundle registers
    logic                out_valid_q,   out_valid_d;
    logic [XLEN-1:0]     data_a_q,      data_a_d;
    logic [XLEN-1:0]     data_b_q,      data_b_d;
    logic [XLEN-1:0]     store_data_q,  store_data_d;
    logic [OP_WIDTH-1:0] exec_op_q,     exec_op_d;
    logic                cond_branch_q, cond_branch_d;
    logic                taken_q,       taken_d;
    logic                jalr_q,        jalr_d;
    logic [XLEN-1:0]     imm_q,         imm_d;
    logic [XLEN-1:0]     pc_q,          pc_d;
    logic [XLEN-1:0]     jalr_target_q, jalr_target_d;

    logic [AW-1:0]   src_rs  [2];
    logic [XLEN-1:0] src_val [2];
    logic [XLEN-1:0] jalr_sum;
    logic            hazard;
    logic            accept;

    assign src_rs[0] = rs_a;
    assign src_rs[1] = rs_b;

    // Operand resolution, youngest producer first. The WB term covers a write
    // landing on the same edge the read is accepted.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            if (src_rs[s] == '0)
                src_val[s] = '0;
            else if (ex_fwd_en && ex_fwd_rd == src_rs[s])
                src_val[s] = ex_fwd_data;
            else if (mem_fwd_en && mem_fwd_rd == src_rs[s])
                src_val[s] = mem_fwd_data;
            else if (wb_en && wb_rd == src_rs[s])
                src_val[s] = wb_data;
            else
                src_val[s] = rf_q[src_rs[s]];
        end
    end

    // A load in execute has no data yet; rs_a only matters when it is not
    // replaced by the PC. rs_b always matters because it feeds store_data.
    always_comb begin
        hazard = ex_fwd_en && ex_fwd_is_load && (ex_fwd_rd != '0) &&
                 ((!pc_for_a && ex_fwd_rd == rs_a) || (ex_fwd_rd == rs_b));
    end

    assign in_ready = !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign jalr_sum = src_val[0] + imm;

    always_comb begin
        rf_d = rf_q;
        if (wb_en && wb_rd != '0)
            rf_d[wb_rd] = wb_data;
    end

    always_comb begin
        data_a_d      = data_a_q;
        data_b_d      = data_b_q;
        store_data_d  = store_data_q;
        exec_op_d     = exec_op_q;
        cond_branch_d = cond_branch_q;
        taken_d       = taken_q;
        jalr_d        = jalr_q;
        imm_d         = imm_q;
        pc_d          = pc_q;
        jalr_target_d = jalr_target_q;

        // EMPTY/FULL occupancy: flush wins, then a new bundle, then drain.
        if (flush)
            out_valid_d = 1'b0;
        else if (accept)
            out_valid_d = 1'b1;
        else if (out_ready)
            out_valid_d = 1'b0;
        else
            out_valid_d = out_valid_q;

        if (accept) begin
            data_a_d      = pc_for_a  ? pc  : src_val[0];
            data_b_d      = imm_for_b ? imm : src_val[1];
            store_data_d  = src_val[1];
            exec_op_d     = exec_op;
            cond_branch_d = cond_branch;
            taken_d       = taken;
            jalr_d        = jalr;
            imm_d         = imm;
            pc_d          = pc;
            // Target only tracks JALR bundles; other bundles leave the last one.
            if (jalr)
                jalr_target_d = {jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++)
                rf_q[i] <= '0;
            out_valid_q   <= 1'b0;
            data_a_q      <= '0;
            data_b_q      <= '0;
            store_data_q  <= '0;
            exec_op_q     <= '0;
            cond_branch_q <= 1'b0;
            taken_q       <= 1'b0;
            jalr_q        <= 1'b0;
            imm_q         <= '0;
            pc_q          <= '0;
            jalr_target_q <= '0;
        end else begin
            rf_q          <= rf_d;
            out_valid_q   <= out_valid_d;
            data_a_q      <= data_a_d;
            data_b_q      <= data_b_d;
            store_data_q  <= store_data_d;
            exec_op_q     <= exec_op_d;
            cond_branch_q <= cond_branch_d;
            taken_q       <= taken_d;
            jalr_q        <= jalr_d;
            imm_q         <= imm_d;
            pc_q          <= pc_d;
            jalr_target_q <= jalr_target_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign data_a          = data_a_q;
    assign data_b          = data_b_q;
    assign store_data      = store_data_q;
    assign exec_op_out     = exec_op_q;
    assign cond_branch_out = cond_branch_q;
    assign taken_out       = taken_q;
    assign jalr_out        = jalr_q;
    assign imm_out         = imm_q;
    assign pc_out          = pc_q;
    assign jalr_target     = jalr_target_q;

endmodule

// File: doc/register_read_stage.md
# register_read_stage

Pipelined register-read stage sitting between decode and execute. It owns the integer register file and resolves operands with forwarding from the execute, memory and write-back stages. It computes the JALR target and presents a registered operand bundle to execute under a valid/ready handshake, with load-use stall and flush support. It supersedes the fixed 32-bit, always-advancing register access stage with a parametrised, backpressure-aware design.

## Interface
Parameters:
- XLEN, 32, datapath, PC and immediate width
- REG_COUNT, 32, architectural registers (power of two); AW = log2(REG_COUNT)
- OP_WIDTH, 5, execute-opcode width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode bundle valid
- in_ready  out  1  stage can accept this cycle
- rs_a, rs_b  in  AW  source register numbers
- pc_for_a, imm_for_b  in  1  operand-select: PC replaces A, immediate replaces B
- pc, imm  in  XLEN  instruction PC, sign-extended immediate
- exec_op  in  OP_WIDTH  execute opcode
- cond_branch, taken, jalr  in  1  branch class, predicted-taken, JALR flag
- wb_en  in  1; wb_rd  in  AW; wb_data  in  XLEN  write-back port
- ex_fwd_en  in  1; ex_fwd_rd  in  AW; ex_fwd_data  in  XLEN; ex_fwd_is_load  in  1  execute-stage result
- mem_fwd_en  in  1; mem_fwd_rd  in  AW; mem_fwd_data  in  XLEN  memory-stage result
- flush  in  1  discard in-flight and incoming bundle
- out_valid  out  1; out_ready  in  1  downstream handshake
- data_a, data_b  out  XLEN  resolved operands
- store_data  out  XLEN  resolved rs_b value, ignoring imm_for_b
- exec_op_out  out  OP_WIDTH; cond_branch_out, taken_out, jalr_out  out  1
- imm_out, pc_out  out  XLEN
- jalr_target  out  XLEN  (resolved rs_a + imm) with bit 0 cleared

## Operation
- Register file: REG_COUNT × XLEN, written when wb_en && wb_rd != 0. Register 0 always reads zero, and writes to it are ignored.
- Operand resolution per source (rs_a, rs_b), first match wins:
  - rs == 0 → 0
  - ex_fwd_en && ex_fwd_rd == rs → ex_fwd_data
  - mem_fwd_en && mem_fwd_rd == rs → mem_fwd_data
  - wb_en && wb_rd == rs → wb_data (write-through)
  - otherwise the register file
- data_a = pc_for_a ? pc : resolved A. data_b = imm_for_b ? imm : resolved B.
- jalr_target = (resolved A + imm) mod 2^XLEN, with bit 0 forced to 0. It is valid only when jalr_out = 1; otherwise it holds its previous value.
- Load-use hazard: ex_fwd_en && ex_fwd_is_load && ex_fwd_rd != 0, and ex_fwd_rd matches rs_a (when !pc_for_a) or rs_b.
  - hazard forces in_ready = 0
- in_ready = !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready && !flush. On accept, all output registers load from the resolved values.
- Output register states:
  - EMPTY (out_valid = 0)
  - FULL (out_valid = 1)
- Transitions:
  - FULL && out_ready && !accept → EMPTY
  - accept → FULL, from either state
  - FULL && !out_ready → hold all outputs stable
- Flush has priority: the next state is EMPTY and the incoming bundle is dropped. Write-back still updates the register file.

## Timing
- Latency is 1 cycle: a bundle accepted at edge N appears with out_valid = 1 after edge N.
- Throughput is 1 bundle/cycle when out_ready = 1 and no hazard.
- in_ready is combinational from out_valid, out_ready and the hazard terms. Operand resolution is combinational, sampled at the accepting edge.
- A write-back at edge N is visible to a read accepted at edge N via the bypass, and via the file after N.
- Reset at any edge:
  - out_valid = 0
  - all output data, jalr_target and control outputs = 0
  - all registers cleared to 0
  - any in-flight bundle is discarded
  - in_ready = 1 once rst deasserts, subject to hazard
- rst and flush together: reset behaviour.
- A stall on the hazard lasts exactly as long as the condition holds, typically 1 cycle.

## Test plan
- Reset, then write x5 = 0x1234 via WB. Read rs_a = 5, rs_b = 0 → data_a = 0x1234, data_b = 0, out_valid one cycle after accept.
- Read x7 while ex_fwd (rd 7, 0xAAAA), mem_fwd (rd 7, 0xBBBB) and wb (rd 7, 0xCCCC) are all active → data_a = 0xAAAA. Drop ex → 0xBBBB. Drop mem → 0xCCCC.
- ex_fwd_is_load = 1 with rd = 3, decode reads rs_b = 3 → in_ready = 0 for that cycle. After the load leaves, the bundle is accepted with mem_fwd_data.
- out_ready held 0 for 3 cycles with out_valid = 1 → outputs stable, in_ready = 0. Release → the next bundle appears the cycle after.
- jalr with x1 = 0x1001, imm = 0x10 → jalr_target = 0x1010, jalr_out = 1. A write to x0 followed by a read of x0 → 0.
- Flush asserted with in_valid = 1 and out_valid = 1 → out_valid = 0 next cycle and the incoming bundle never appears. Assert rst mid-stall → all outputs 0.
